// File: rtl/median_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : median_frame_ctrl
// Description : Frame sequencer for the 3x3 median path. Holds the xy counter
//               back until the line buffers are primed, flushes the pipeline
//               with pad beats at frame end, flags border pixels and reports
//               frame completion.
// Revision    : 1.0 - initial release
// ============================================================================
module median_frame_ctrl #(
    parameter int imwidth  = 640,
    parameter int imheight = 480,
    parameter int x_bit    = 10,
    parameter int y_bit    = 10,
    parameter int LAT      = 641,
    parameter int LAT_BIT  = 11,
    parameter int PIX_BIT  = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof_in,
    input  logic             datavalid_in,
    input  logic [x_bit-1:0] x,
    input  logic [y_bit-1:0] y,
    output logic             lat_end,
    output logic             dv_out,
    output logic             pad_sel,
    output logic             border,
    output logic             busy,
    output logic             frame_done,
    output logic             err_sof
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam logic [PIX_BIT-1:0] C_PIX_LAST = PIX_BIT'(imwidth * imheight - 1);
    localparam logic [LAT_BIT-1:0] C_LAT_LAST = LAT_BIT'(LAT - 1);
    localparam logic [x_bit-1:0]   C_X_LAST   = x_bit'(imwidth - 1);
    localparam logic [y_bit-1:0]   C_Y_LAST   = y_bit'(imheight - 1);
    // With a one-beat latency the first pixel already primes the window.
    localparam state_t             C_START_ST = (LAT == 1) ? S_RUN : S_FILL;

    state_t             state_q, state_d;
    logic [LAT_BIT-1:0] fill_cnt_q, fill_cnt_d;
    logic [LAT_BIT-1:0] flush_cnt_q, flush_cnt_d;
    logic [PIX_BIT-1:0] pix_cnt_q, pix_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic               err_sof_q, err_sof_d;
    logic               w_start;

    assign w_start = sof_in & datavalid_in;

    // Status outputs decode straight from the state register.
    assign lat_end    = (state_q == S_RUN) | (state_q == S_FLUSH);
    assign pad_sel    = (state_q == S_FLUSH);
    assign dv_out     = ((state_q == S_RUN) & datavalid_in) | (state_q == S_FLUSH);
    assign busy       = (state_q != S_IDLE);
    assign border     = dv_out & ((x == '0) | (x == C_X_LAST) |
                                  (y == '0) | (y == C_Y_LAST));
    assign frame_done = frame_done_q;
    assign err_sof    = err_sof_q;

    // State register and counters; async active-low reset returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= '0;
            flush_cnt_q  <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
            err_sof_q    <= err_sof_d;
        end
    end

    // Next-state logic: priming, pixel run, pad flush and mid-frame restarts.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        err_sof_d    = err_sof_q;

        if (w_start) begin
            // A start beat is always pixel 1 of a fresh frame; mid-frame it
            // abandons the current frame without a done pulse.
            if (state_q != S_IDLE) begin
                err_sof_d = 1'b1;
            end
            state_d     = C_START_ST;
            fill_cnt_d  = LAT_BIT'(1);
            pix_cnt_d   = PIX_BIT'(1);
            flush_cnt_d = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (datavalid_in) begin
                        fill_cnt_d = fill_cnt_q + LAT_BIT'(1);
                        pix_cnt_d  = pix_cnt_q + PIX_BIT'(1);
                        if (fill_cnt_q == C_LAT_LAST) begin
                            state_d = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (datavalid_in) begin
                        pix_cnt_d = pix_cnt_q + PIX_BIT'(1);
                        if (pix_cnt_q == C_PIX_LAST) begin
                            state_d     = S_FLUSH;
                            flush_cnt_d = '0;
                        end
                    end
                end
                S_FLUSH: begin
                    // One pad beat per cycle; input beats are dropped.
                    flush_cnt_d = flush_cnt_q + LAT_BIT'(1);
                    if (flush_cnt_q == C_LAT_LAST) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
